// File: rtl/audio_meter_pkg.sv
// Shared types for the audio level/frequency meter: FSM states and the
// default-configuration per-channel sample and result layouts.
package audio_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int DEF_SMPL_W = 16;
    localparam int DEF_CNT_W  = 12;
    localparam int DEF_IDX_W  = 11;

    typedef logic signed [DEF_SMPL_W-1:0] sample_t;

    typedef struct packed {
        sample_t                max_v;
        sample_t                min_v;
        logic [DEF_CNT_W-1:0]   cnt;
        logic [DEF_IDX_W-1:0]   span;
        logic                   sat;
    } ch_result_t;

endpackage

// File: rtl/audio_meter_if.sv
// Sample/control/result bundle of audio_meter; the master drives the strobes,
// the slave (the meter) returns status and per-channel results.
interface audio_meter_if
    import audio_meter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int SMPL_W = 16,
    parameter int CNT_W  = 12,
    parameter int IDX_W  = 11
);
    // start and smpl_vld are single-cycle strobes with no back-pressure: the
    // meter always samples them; start is simply dropped while busy is high.
    logic                       start;
    logic                       smpl_vld;
    logic [NUM_CH*SMPL_W-1:0]   smpl;
    logic                       busy;
    logic                       done;
    logic [NUM_CH*SMPL_W-1:0]   peak_max;
    logic [NUM_CH*SMPL_W-1:0]   peak_min;
    logic [NUM_CH*CNT_W-1:0]    xing_cnt;
    logic [NUM_CH*IDX_W-1:0]    xing_span;
    logic [NUM_CH-1:0]          cnt_sat;
    state_e                     state_dbg;

    modport master (
        output start, smpl_vld, smpl,
        input  busy, done, peak_max, peak_min, xing_cnt, xing_span, cnt_sat, state_dbg
    );

    modport slave (
        input  start, smpl_vld, smpl,
        output busy, done, peak_max, peak_min, xing_cnt, xing_span, cnt_sat, state_dbg
    );

endinterface

// File: rtl/audio_meter_ch.sv
// One channel of the meter: peak tracking, sign-change counting and crossing
// span. Hysteretic sign detection is built when METER_HYST_EN is defined.
module audio_meter_ch
    import audio_meter_pkg::*;
#(
    parameter int SMPL_W = 16,
    parameter int CNT_W  = 12,
    parameter int IDX_W  = 11
`ifdef METER_HYST_EN
    ,
    parameter int HYST   = 100
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prime,
    input  logic                     step,
    input  logic                     latch,
    input  logic [IDX_W-1:0]         idx,
    input  logic signed [SMPL_W-1:0] sample,
    output logic signed [SMPL_W-1:0] res_max,
    output logic signed [SMPL_W-1:0] res_min,
    output logic [CNT_W-1:0]         res_cnt,
    output logic [IDX_W-1:0]         res_span,
    output logic                     res_sat
);

    typedef struct packed {
        logic signed [SMPL_W-1:0] max_v;
        logic signed [SMPL_W-1:0] min_v;
        logic [CNT_W-1:0]         cnt;
        logic [IDX_W-1:0]         span;
        logic                     sat;
    } res_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic signed [SMPL_W-1:0] max_q, max_d, min_q, min_d;
    logic                     known_q, known_d, neg_q, neg_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     sat_q, sat_d;
    logic [IDX_W-1:0]         first_q, first_d, last_q, last_d;
    res_t                     res_q, res_d;
    logic                     cur_valid;
    logic                     cur_neg;

`ifdef METER_HYST_EN
    localparam logic signed [SMPL_W-1:0] HYST_P = SMPL_W'(HYST);
    localparam logic signed [SMPL_W-1:0] HYST_N = -SMPL_W'(HYST);

    // Samples inside the band carry no sign information at all.
    assign cur_valid = (sample > HYST_P) || (sample < HYST_N);
    assign cur_neg   = (sample < HYST_N);
`else
    assign cur_valid = 1'b1;
    assign cur_neg   = sample[SMPL_W-1];
`endif

    always_comb begin
        max_d   = max_q;
        min_d   = min_q;
        known_d = known_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        first_d = first_q;
        last_d  = last_q;
        res_d   = res_q;
        if (prime) begin
            max_d   = sample;
            min_d   = sample;
            known_d = cur_valid;
            neg_d   = cur_neg;
            cnt_d   = '0;
            sat_d   = 1'b0;
            first_d = '0;
            last_d  = '0;
        end else if (step) begin
            if (sample > max_q) max_d = sample;
            if (sample < min_q) min_d = sample;
            if (cur_valid) begin
                if (!known_q) begin
                    // First decisive sample only establishes the reference sign.
                    known_d = 1'b1;
                    neg_d   = cur_neg;
                end else if (cur_neg != neg_q) begin
                    neg_d  = cur_neg;
                    last_d = idx;
                    if (cnt_q == '0) first_d = idx;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (cnt_q >= CNT_MAX - 1'b1) sat_d = 1'b1;
                end
            end
        end
        // Results are taken from the next-state values so they appear with done.
        if (latch) begin
            res_d.max_v = max_d;
            res_d.min_v = min_d;
            res_d.cnt   = cnt_d;
            res_d.span  = (cnt_d != '0) ? (last_d - first_d) : '0;
            res_d.sat   = sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q   <= '0;
            min_q   <= '0;
            known_q <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            first_q <= '0;
            last_q  <= '0;
            res_q   <= '0;
        end else begin
            max_q   <= max_d;
            min_q   <= min_d;
            known_q <= known_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            first_q <= first_d;
            last_q  <= last_d;
            res_q   <= res_d;
        end
    end

    assign res_max  = res_q.max_v;
    assign res_min  = res_q.min_v;
    assign res_cnt  = res_q.cnt;
    assign res_span = res_q.span;
    assign res_sat  = res_q.sat;

endmodule

// File: rtl/audio_meter.sv
// Multi-channel audio meter top: window FSM and sample index shared by all
// channels. Hysteresis is enabled by defining METER_HYST_EN.
module audio_meter
    import audio_meter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int SMPL_W = 16,
    parameter int WINDOW = 2000,
    parameter int CNT_W  = 12
`ifdef METER_HYST_EN
    ,
    parameter int HYST   = 100
`endif
) (
    input  logic          clk,
    input  logic          rst,
    audio_meter_if.slave  bus
);

    localparam int IDX_W = $clog2(WINDOW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             prime, step, latch;

    logic signed [SMPL_W-1:0] max_arr  [NUM_CH];
    logic signed [SMPL_W-1:0] min_arr  [NUM_CH];
    logic [CNT_W-1:0]         cnt_arr  [NUM_CH];
    logic [IDX_W-1:0]         span_arr [NUM_CH];
    logic [NUM_CH-1:0]        sat_vec;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        prime    = 1'b0;
        step     = 1'b0;
        latch    = 1'b0;
        bus.busy = (state_q != IDLE);
        bus.done = 1'b0;
        case (state_q)
            IDLE: begin
                // A strobe arriving with start is not part of the window.
                if (bus.start) state_d = PRIME;
            end
            PRIME: begin
                if (bus.smpl_vld) begin
                    prime   = 1'b1;
                    idx_d   = IDX_W'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (bus.smpl_vld) begin
                    step = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        latch   = 1'b1;
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.state_dbg = state_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        audio_meter_ch #(
            .SMPL_W (SMPL_W),
            .CNT_W  (CNT_W),
            .IDX_W  (IDX_W)
`ifdef METER_HYST_EN
            ,
            .HYST   (HYST)
`endif
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .prime    (prime),
            .step     (step),
            .latch    (latch),
            .idx      (idx_q),
            .sample   (bus.smpl[c*SMPL_W +: SMPL_W]),
            .res_max  (max_arr[c]),
            .res_min  (min_arr[c]),
            .res_cnt  (cnt_arr[c]),
            .res_span (span_arr[c]),
            .res_sat  (sat_vec[c])
        );
    end

    always_comb begin
        bus.peak_max  = '0;
        bus.peak_min  = '0;
        bus.xing_cnt  = '0;
        bus.xing_span = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.peak_max[c*SMPL_W +: SMPL_W] = max_arr[c];
            bus.peak_min[c*SMPL_W +: SMPL_W] = min_arr[c];
            bus.xing_cnt[c*CNT_W +: CNT_W]   = cnt_arr[c];
            bus.xing_span[c*IDX_W +: IDX_W]  = span_arr[c];
        end
    end

    assign bus.cnt_sat = sat_vec;

endmodule

// File: tb/tb_audio_meter.sv
// Directed bench for audio_meter: two instances (12-bit and 4-bit crossing
// counters) share one stimulus stream; right channel is the negated left.
module tb_audio_meter;
    import audio_meter_pkg::*;

    localparam int NUM_CH = 2;
    localparam int SMPL_W = 16;
    localparam int WINDOW = 2000;
    localparam int IDX_W  = $clog2(WINDOW);

`ifdef METER_HYST_EN
    localparam int NZ_CNT  = 199;
    localparam int NZ_SPAN = 1980;
`else
    localparam int NZ_CNT  = 399;
    localparam int NZ_SPAN = 1990;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        smpl_vld = 1'b0;
    logic [31:0] smpl = '0;

    int compares = 0;
    int fails    = 0;
    int done_a   = 0;
    int done_b   = 0;

    always #5 clk = ~clk;

    audio_meter_if #(.NUM_CH(NUM_CH), .SMPL_W(SMPL_W), .CNT_W(12), .IDX_W(IDX_W)) ifa ();
    audio_meter_if #(.NUM_CH(NUM_CH), .SMPL_W(SMPL_W), .CNT_W(4),  .IDX_W(IDX_W)) ifb ();

    assign ifa.start    = start;
    assign ifa.smpl_vld = smpl_vld;
    assign ifa.smpl     = smpl;
    assign ifb.start    = start;
    assign ifb.smpl_vld = smpl_vld;
    assign ifb.smpl     = smpl;

    audio_meter #(.NUM_CH(NUM_CH), .SMPL_W(SMPL_W), .WINDOW(WINDOW), .CNT_W(12)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    audio_meter #(.NUM_CH(NUM_CH), .SMPL_W(SMPL_W), .WINDOW(WINDOW), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    always @(negedge clk) begin
        if (ifa.done === 1'b1) done_a++;
        if (ifb.done === 1'b1) done_b++;
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        compares++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [15:0] square(input int i);
        return (((i / 10) % 2) == 0) ? 16'sd3200 : -16'sd3200;
    endfunction

    // mode 0: square, 1: constant, 2: square with +/-50 at the start of each half
    function automatic logic signed [15:0] gen(input int mode, input int i);
        case (mode)
            0:       return square(i);
            1:       return 16'sd1000;
            default: return ((i % 10) == 0) ? 16'sd50 :
                            ((i % 10) == 1) ? -16'sd50 : square(i);
        endcase
    endfunction

    task automatic send(input logic signed [15:0] s0, input logic go);
        logic signed [15:0] s1;
        s1       = -s0;
        smpl     = {s1, s0};
        smpl_vld = 1'b1;
        start    = go;
        @(posedge clk);
        #1;
        smpl_vld = 1'b0;
        start    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_meas(input logic junk);
        start = 1'b1;
        if (junk) begin
            smpl     = {16'sd30000, 16'sd30000};
            smpl_vld = 1'b1;
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        smpl_vld = 1'b0;
    endtask

    task automatic feed(input int mode, input int first, input int last, input bit gaps, input int start_at);
        for (int i = first; i <= last; i++) begin
            send(gen(mode, i), i == start_at);
            if (gaps && (i % 3 == 0) && (i != last)) idle(1);
        end
    endtask

    task automatic check_res(input string t, input int mx0, input int mn0, input int mx1, input int mn1,
                             input int cnt, input int span, input int cnt_b, input int sat_b);
        check({t, "_max0"},   $signed(ifa.peak_max[15:0]),  mx0);
        check({t, "_min0"},   $signed(ifa.peak_min[15:0]),  mn0);
        check({t, "_max1"},   $signed(ifa.peak_max[31:16]), mx1);
        check({t, "_min1"},   $signed(ifa.peak_min[31:16]), mn1);
        check({t, "_cnt0"},   ifa.xing_cnt[11:0],  cnt);
        check({t, "_cnt1"},   ifa.xing_cnt[23:12], cnt);
        check({t, "_span0"},  ifa.xing_span[10:0], span);
        check({t, "_span1"},  ifa.xing_span[21:11], span);
        check({t, "_sat_a"},  ifa.cnt_sat, 0);
        check({t, "_cntb0"},  ifb.xing_cnt[3:0], cnt_b);
        check({t, "_cntb1"},  ifb.xing_cnt[7:4], cnt_b);
        check({t, "_spanb0"}, ifb.xing_span[10:0], span);
        check({t, "_sat_b"},  ifb.cnt_sat, sat_b ? 3 : 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",  ifa.busy, 0);
        check("rst_done",  ifa.done, 0);
        check("rst_state", ifa.state_dbg, IDLE);
        check("rst_max",   ifa.peak_max, 0);
        check("rst_cnt",   ifa.xing_cnt, 0);
        check("rst_span",  ifa.xing_span, 0);
        check("rst_sat",   ifb.cnt_sat, 0);

        // Square wave with idle gaps; the strobe coincident with start must be ignored
        begin_meas(1'b1);
        @(negedge clk);
        check("sq_busy_rise", ifa.busy, 1);
        check("sq_state_prime", ifa.state_dbg, PRIME);
        feed(0, 0, 1998, 1'b1, -1);
        @(negedge clk);
        check("sq_no_early_done", ifa.done, 0);
        check("sq_busy_mid", ifa.busy, 1);
        feed(0, 1999, 1999, 1'b0, -1);
        @(negedge clk);
        check("sq_done", ifa.done, 1);
        check("sq_done_b", ifb.done, 1);
        check_res("sq", 3200, -3200, 3200, -3200, 199, 1980, 15, 1);
        @(negedge clk);
        check("sq_busy_fall", ifa.busy, 0);
        check("sq_done_fall", ifa.done, 0);
        check("sq_done_count", done_a, 1);

        // Constant input; start pulsed mid-window must be ignored
        begin_meas(1'b0);
        feed(1, 0, 1999, 1'b0, 700);
        @(negedge clk);
        check("const_done", ifa.done, 1);
        check_res("const", 1000, 1000, -1000, -1000, 0, 0, 0, 0);
        @(negedge clk);
        check("const_busy_fall", ifa.busy, 0);
        check("const_done_count", done_a, 2);
        check("const_done_count_b", done_b, 2);

        // Small-amplitude chatter near each edge of the square
        begin_meas(1'b0);
        feed(2, 0, 1999, 1'b0, -1);
        @(negedge clk);
        check("nz_done", ifa.done, 1);
        check_res("nz", 3200, -3200, 3200, -3200, NZ_CNT, NZ_SPAN, 15, 1);
        @(negedge clk);
        check("nz_done_count", done_a, 3);

        // Reset with idx at 700 clears everything and produces no done
        begin_meas(1'b0);
        feed(0, 0, 699, 1'b0, -1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_busy",  ifa.busy, 0);
        check("mrst_state", ifa.state_dbg, IDLE);
        check("mrst_max",   ifa.peak_max, 0);
        check("mrst_min",   ifa.peak_min, 0);
        check("mrst_cnt",   ifa.xing_cnt, 0);
        check("mrst_span",  ifa.xing_span, 0);
        check("mrst_sat_b", ifb.cnt_sat, 0);
        idle(3);
        @(negedge clk);
        check("mrst_no_done", done_a, 3);

        // Fresh measurement after the aborted one
        begin_meas(1'b0);
        feed(0, 0, 1999, 1'b1, -1);
        @(negedge clk);
        check("fresh_done", ifa.done, 1);
        check_res("fresh", 3200, -3200, 3200, -3200, 199, 1980, 15, 1);
        @(negedge clk);
        check("fresh_done_count", done_a, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

// File: doc/audio_meter.md
Name: audio_meter

Overview:
- Synthesizable, multi-channel successor to the bench-side audio frequency/amplitude checker.
- Takes decimated audio samples, one strobe per LRCLK frame, for NUM_CH channels.
- Over a programmable window it measures per channel: peak max, peak min, zero-crossing count, and sample span between the first and last crossing.
- Sits after the CODEC receive path in Equalizer. Feeds LED/debug readout and self-check logic.
- Frequency = fs*(xing_cnt-1)/(2*xing_span). The division is left to the consumer; there is no divider in this block.

Parameters:
- NUM_CH, 2, number of audio channels (channel 0 = left, 1 = right).
- SMPL_W, 16, signed sample width.
- WINDOW, 2000, samples per measurement, including the priming sample; must be >= 2.
- CNT_W, 12, crossing counter width; saturating.
- HYST, 100, hysteresis threshold magnitude (used only with METER_HYST_EN).
- Localparam IDX_W = $clog2(WINDOW).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement.
- smpl_vld  in  1  one-cycle strobe; smpl is valid this cycle.
- smpl  in  NUM_CH*SMPL_W  packed signed samples; channel c at [c*SMPL_W +: SMPL_W].
- busy  out  1  high from accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; results updated the same cycle.
- peak_max  out  NUM_CH*SMPL_W  per-channel signed maximum.
- peak_min  out  NUM_CH*SMPL_W  per-channel signed minimum.
- xing_cnt  out  NUM_CH*CNT_W  per-channel crossing count.
- xing_span  out  NUM_CH*IDX_W  last crossing index minus first crossing index.
- cnt_sat  out  NUM_CH  per-channel flag: crossing counter saturated.

Behaviour:
- Reset: state IDLE; busy=0, done=0. All result outputs and cnt_sat are 0. All internal trackers are cleared.
- FSM states: IDLE, PRIME, MEASURE, DONE.
- IDLE: start=1 -> PRIME; busy rises the next cycle.
- PRIME:
  - Waits for smpl_vld. That sample is index 0.
  - Per channel: max=min=sample, sign state = sample MSB (zero counts as positive), cnt=0, first/last index=0.
  - Then -> MEASURE. idx=1.
- MEASURE:
  - Each smpl_vld processes sample at index idx.
  - Updates max/min with signed compare.
  - A crossing occurs when the current sign differs from the stored sign. On a crossing:
    - store the new sign;
    - cnt++ (saturates at 2^CNT_W-1, sets cnt_sat);
    - if this is the first crossing, first=idx;
    - last=idx.
  - After processing idx=WINDOW-1 -> DONE.
  - Cycles without smpl_vld hold all state.
- DONE (one cycle):
  - done=1. Results are latched: span = cnt>=1 ? last-first : 0.
  - -> IDLE. busy=0 the next cycle.
- Results hold until the next DONE or reset.
- start while busy is ignored.
- start and smpl_vld in the same IDLE cycle: that sample is not consumed; PRIME waits for the next strobe.
- Reset mid-operation: immediate return to IDLE. Results are cleared and there is no done pulse.
- Latency from the final sample strobe to done: 1 cycle.
- All channels share the FSM and idx and are processed in parallel.

Optional Feature:
- METER_HYST_EN defined:
  - The sign state goes positive only when sample > +HYST and negative only when sample < -HYST.
  - Samples in [-HYST, +HYST] leave the state unchanged and count no crossing.
  - The priming sample sets the state only if it is outside the band. Otherwise the state is "unknown", and the first out-of-band sample sets it without counting a crossing.
- METER_HYST_EN undefined: plain MSB sign-change detection; the HYST parameter is unused.

Decomposition:
- Package audio_meter_pkg:
  - state enum {IDLE, PRIME, MEASURE, DONE};
  - signed sample typedef;
  - per-channel result struct (max, min, cnt, span, sat).
- Sub-module audio_meter_ch (one per channel, generate loop):
  - holds max/min/sign/cnt/first/last;
  - inputs: prime, step, idx, sample, latch.
- The top holds the FSM and idx counter.

Test Plan:
- Square wave ±3200, 10 samples per half period, WINDOW=2000, NUM_CH=2 (right inverted) -> both channels: xing_cnt=199, xing_span=1980, peak_max=3200, peak_min=-3200, cnt_sat=0, one done pulse.
- Constant +1000 on channel 0 -> xing_cnt=0, xing_span=0, peak_max=peak_min=1000.
- CNT_W=4 with the square wave above -> xing_cnt=15, cnt_sat=1, xing_span=1980.
- Alternating ±50 around a +3200/-3200 square with HYST=100:
  - with METER_HYST_EN: xing_cnt=199;
  - without it: the count far exceeds 199.
- start pulsed again during MEASURE -> ignored; exactly one done pulse 2000 strobes after priming.
- rst asserted at idx=700 -> the next cycle busy=0 and all results 0, with no done pulse. A fresh start measures normally.
